// File: rtl/uart_tx_fifo.sv
// UART transmitter with a word FIFO in front of the serialiser.
// Frame: start, DATA_WIDTH bits LSB-first, optional parity, 1 or 2 stops.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]         wptr_q, rptr_q;
  logic                  empty, full, push, pop;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_q;
  logic [BW-1:0]         bitcnt_q;
  logic [DIV_WIDTH-1:0]  baud_q, div_q;
  logic [1:0]            pmode_q;
  logic                  two_q;
  logic                  so_q;
  logic                  line_d;
  logic                  bit_end;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = wr_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;

  assign wr_ready   = !full;
  assign fifo_count = wptr_q - rptr_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign serial_out = so_q;
  assign bit_end    = (baud_q == div_q);

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wptr_q <= '0;
    else if (push) wptr_q <= wptr_q + CW'(1);
  end

  // Line level for the bit currently being held; registered below.
  always_comb begin
    line_d = 1'b1;
    unique case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_q[0];
      PARITY:  line_d = par_q ^ pmode_q[1];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      baud_q   <= '0;
      div_q    <= '0;
      pmode_q  <= '0;
      two_q    <= 1'b0;
      so_q     <= 1'b1;
      rptr_q   <= '0;
    end else begin
      so_q <= line_d;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rptr_q[AW-1:0]];
            rptr_q   <= rptr_q + CW'(1);
            div_q    <= baud_div;
            pmode_q  <= parity_mode;
            two_q    <= two_stop;
            par_q    <= 1'b0;
            bitcnt_q <= '0;
            baud_q   <= '0;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            par_q   <= par_q ^ shift_q[0];
            shift_q <= shift_q >> 1;
            if (bitcnt_q == BW'(DATA_WIDTH - 1)) begin
              bitcnt_q <= '0;
              state_q  <= (^pmode_q) ? PARITY : STOP;
            end else begin
              bitcnt_q <= bitcnt_q + BW'(1);
            end
          end else begin
            baud_q <= baud_q + DIV_WIDTH'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (two_q && bitcnt_q == '0) begin
              bitcnt_q <= BW'(1);
            end else begin
              bitcnt_q <= '0;
              state_q  <= IDLE;
            end
          end else begin
            baud_q <= baud_q + DIV_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame table, corner sequences, random traffic
// against a frame-level model of the line.
module tb_uart_tx_fifo;

  localparam int DW    = 20;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [DW-1:0]   wr_data = '0;
  logic [DIVW-1:0] baud_div = '0;
  logic [1:0]      parity_mode = 2'b00;
  logic            two_stop = 1'b0;
  logic            serial_out;
  logic            busy;
  logic [2:0]      fifo_count;

  uart_tx_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .serial_out(serial_out), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: queued words, and the one frame on the line as a bit list
  // starting the clock after its pop edge.
  logic [DW-1:0] mq[$];
  int            cyc = 0;
  int            free_at = 0;
  bit            has_frame = 0;
  int            fp, fd, fl;
  logic [63:0]   fbits;

  function automatic logic exp_line(int k);
    if (has_frame && k >= fp + 1 && k <= fp + fl)
      return fbits[(k - fp - 1) / (fd + 1)];
    return 1'b1;
  endfunction

  task automatic start_frame(logic [DW-1:0] w);
    int nb;
    fbits = '1;
    fbits[0] = 1'b0;
    for (int i = 0; i < DW; i++) fbits[1 + i] = w[i];
    nb = DW + 1;
    if (parity_mode == 2'b01 || parity_mode == 2'b10) begin
      fbits[nb] = (^w) ^ (parity_mode == 2'b10);
      nb++;
    end
    nb += two_stop ? 2 : 1;
    fp = cyc;
    fd = int'(baud_div);
    fl = nb * (fd + 1);
    free_at = cyc + fl + 1;
    has_frame = 1;
  endtask

  task automatic step();
    int sz;
    bit do_push, do_pop;
    logic [DW-1:0] w;
    sz = mq.size();
    chk("wr_ready", wr_ready, sz < DEPTH);
    do_push = wr_valid && (sz < DEPTH);
    do_pop  = (cyc >= free_at) && (sz > 0);
    if (do_pop) begin
      w = mq.pop_front();
      start_frame(w);
    end
    if (do_push) mq.push_back(wr_data);
    @(posedge clock);
    #1;
    chk("serial_out", serial_out, exp_line(cyc));
    chk("fifo_count", fifo_count, mq.size());
    chk("busy", busy, (cyc <= free_at - 2) || (mq.size() > 0));
    cyc++;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    #1;
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    repeat (n) begin
      @(posedge clock);
      cyc++;
    end
    #1;
    reset = 1'b0;
    mq.delete();
    has_frame = 0;
    free_at = 0;
  endtask

  task automatic drain(int budget);
    int t = 0;
    while (busy && t < budget) begin
      step();
      t++;
    end
    chk("drain_done", busy, 1'b0);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            div;
    logic [1:0]    pmode;
    logic          two;
    logic          par;
    int            bits;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{20'hA5A5A, 8, 2'b00, 1'b0, 1'b0, 22};
    vt[1] = '{20'h00007, 0, 2'b01, 1'b1, 1'b1, 24};
    vt[2] = '{20'h00007, 0, 2'b10, 1'b1, 1'b0, 24};
    vt[3] = '{20'hFFFFF, 1, 2'b01, 1'b0, 1'b0, 23};
    vt[4] = '{20'h00000, 2, 2'b10, 1'b0, 1'b1, 23};
    vt[5] = '{20'h12345, 3, 2'b11, 1'b1, 1'b0, 23};

    @(posedge clock);
    #1;
    do_reset(3);
    repeat (50) step();
    chk("idle_line", serial_out, 1'b1);
    chk("idle_busy", busy, 1'b0);

    for (int v = 0; v < 6; v++) begin
      logic cap[$];
      logic [DW-1:0] rx;
      int t, d, sb;
      d = vt[v].div;
      baud_div = DIVW'(d);
      parity_mode = vt[v].pmode;
      two_stop = vt[v].two;
      wr_data = vt[v].data;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      t = 0;
      while (serial_out !== 1'b0 && t < 40) begin
        step();
        t++;
      end
      chk("tbl_fall", serial_out, 1'b0);
      cap.delete();
      cap.push_back(serial_out);
      for (int i = 1; i < vt[v].bits * (d + 1); i++) begin
        step();
        cap.push_back(serial_out);
      end
      chk("tbl_start", cap[d / 2], 1'b0);
      for (int j = 0; j < DW; j++) rx[j] = cap[(1 + j) * (d + 1) + d / 2];
      chk("tbl_data", rx, vt[v].data);
      if (vt[v].pmode == 2'b01 || vt[v].pmode == 2'b10)
        chk("tbl_parity", cap[(DW + 1) * (d + 1) + d / 2], vt[v].par);
      sb = vt[v].bits - (vt[v].two ? 2 : 1);
      for (int j = sb; j < vt[v].bits; j++)
        chk("tbl_stop", cap[j * (d + 1) + d / 2], 1'b1);
      drain(10);
    end

    begin
      logic [DW-1:0] words[6];
      int idx = 0;
      int t = 0;
      bit acc;
      for (int i = 0; i < 6; i++) words[i] = DW'(32'h11111 * (i + 1));
      baud_div = 16'd3;
      parity_mode = 2'b00;
      two_stop = 1'b0;
      wr_valid = 1'b1;
      while (idx < 6 && t < 300) begin
        wr_data = words[idx];
        acc = wr_ready;
        step();
        if (acc) idx++;
        t++;
        if (t == 5) begin
          chk("full_count", fifo_count, 4);
          chk("full_ready", wr_ready, 1'b0);
          chk("full_idx", idx, 5);
        end
      end
      wr_valid = 1'b0;
      chk("full_all_acc", idx, 6);
      drain(1000);
    end

    baud_div = 16'd8;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    wr_data = 20'h0F0F0;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    repeat (40) step();
    baud_div = 16'd2;
    wr_data = 20'h3C3C3;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    drain(500);

    baud_div = 16'd8;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = DW'(32'hABC00 + i);
      step();
    end
    wr_valid = 1'b0;
    chk("mid_count", fifo_count, 2);
    begin
      int t = 0;
      while (serial_out !== 1'b0 && t < 20) begin
        step();
        t++;
      end
    end
    chk("mid_fall", serial_out, 1'b0);
    repeat (5 * 9 + 4) step();
    chk("mid_busy", busy, 1'b1);
    do_reset(3);
    repeat (300) step();
    chk("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data = DW'($urandom);
      baud_div = DIVW'($urandom_range(0, 2));
      parity_mode = 2'($urandom_range(0, 3));
      two_stop = 1'($urandom_range(0, 1));
      step();
    end
    wr_valid = 1'b0;
    drain(2000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
